// File: rtl/fractal_pkg.sv
// Shared constants for the fractal coefficient path: word/beat geometry,
// packer FSM state encoding and a beat-position helper.
package fractal_pkg;

  localparam int COEFF_W         = 128;
  localparam int BEAT_W          = 32;
  localparam int BEATS_PER_COEFF = COEFF_W / BEAT_W;

  // Packer FSM encoding (kept as plain constants for legacy tooling)
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Right-shift that brings beat 'beat_idx' (0 = most significant) to bit 0.
  function automatic int beat_shift(input int beat_idx, input int beat_w);
    return COEFF_W - beat_w * (beat_idx + 1);
  endfunction

endpackage

// File: rtl/coeff_stream_packer_if.sv
// Coefficient capture port plus the valid/ready beat stream of the packer.
// master = the packer, slave = encoder/sink side.
interface coeff_stream_packer_if #(
  parameter int COEFF_W = fractal_pkg::COEFF_W,
  parameter int BEAT_W  = fractal_pkg::BEAT_W
);

  logic [COEFF_W-1:0] coeff_in;
  logic               coeff_valid;
  logic [BEAT_W-1:0]  m_data;
  logic               m_valid;
  logic               m_ready;
  logic               m_last;

  modport master (
    input  coeff_in, coeff_valid, m_ready,
    output m_data, m_valid, m_last
  );

  modport slave (
    output coeff_in, coeff_valid, m_ready,
    input  m_data, m_valid, m_last
  );

endinterface

// File: rtl/coeff_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head output.
// head_nxt is the value rd_data will hold after this edge, so a consumer that
// registers its own output can load the new head without a bubble.
module coeff_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [WIDTH-1:0]           head_nxt,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_ptr_inc_s;
  logic [LVL_W-1:0] count_r;
  logic [WIDTH-1:0] rd_data_r;
  logic [WIDTH-1:0] head_nxt_s;
  logic             full_s;
  logic             empty_s;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full_s   = (count_r == LVL_W'(DEPTH));
  assign empty_s  = (count_r == {LVL_W{1'b0}});
  assign full     = full_s;
  assign empty    = empty_s;
  assign level    = count_r;
  assign rd_data  = rd_data_r;
  assign head_nxt = head_nxt_s;

  // Qualify requests: a write into a full FIFO is only legal alongside a pop.
  always_comb begin
    wr_en_s      = push & (~full_s | pop);
    rd_en_s      = pop & ~empty_s;
    rd_ptr_inc_s = rd_ptr_r + PTR_W'(1);
  end

  // Head after this edge, bypassing the write data when it becomes the head.
  always_comb begin
    head_nxt_s = mem_r[rd_ptr_r];
    if (rd_en_s) begin
      if (count_r == LVL_W'(1)) begin
        head_nxt_s = wr_data;
      end else begin
        head_nxt_s = mem_r[rd_ptr_inc_s];
      end
    end else if (empty_s) begin
      head_nxt_s = wr_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_r];
    end
  end

  // Storage array write port (no reset needed on payload).
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {LVL_W{1'b0}};
      rd_data_r <= {WIDTH{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_inc_s;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + LVL_W'(1);
        2'b01:   count_r <= count_r - LVL_W'(1);
        default: count_r <= count_r;
      endcase
      rd_data_r <= head_nxt_s;
    end
  end

endmodule

// File: rtl/coeff_stream_packer.sv
// Captures 128-bit fractal coefficients on a single-cycle valid pulse, buffers
// them and serialises each as MSB-first beats on a valid/ready stream.
// The producer cannot be stalled, so words arriving on a full buffer are
// dropped and reported through a sticky flag and a saturating counter.
module coeff_stream_packer import fractal_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int BEAT_W = fractal_pkg::BEAT_W,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  coeff_stream_packer_if.master      bus,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_count,
  input  logic                       clr_status
);

  localparam int BEATS      = COEFF_W / BEAT_W;
  localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LVL_W      = $clog2(DEPTH+1);

  logic [0:0]            state_r;
  logic [BEAT_IDX_W-1:0] beat_r;
  logic [BEAT_IDX_W-1:0] beat_inc_s;
  logic [BEAT_W-1:0]     m_data_r;
  logic                  m_valid_r;
  logic                  m_last_r;
  logic                  overflow_r;
  logic [CNT_W-1:0]      drop_cnt_r;

  logic                  hs_s;
  logic                  pop_s;
  logic                  push_ok_s;
  logic                  drop_s;
  logic                  remain_s;
  logic [BEAT_W-1:0]     first_slice_s;
  logic [BEAT_W-1:0]     next_slice_s;

  logic [COEFF_W-1:0]    fifo_rd_data_s;
  logic [COEFF_W-1:0]    fifo_head_nxt_s;
  logic [LVL_W-1:0]      fifo_level_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;

  coeff_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (COEFF_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_ok_s),
    .wr_data  (bus.coeff_in),
    .pop      (pop_s),
    .rd_data  (fifo_rd_data_s),
    .head_nxt (fifo_head_nxt_s),
    .level    (fifo_level_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  assign bus.m_data  = m_data_r;
  assign bus.m_valid = m_valid_r;
  assign bus.m_last  = m_last_r;
  assign fifo_level  = fifo_level_s;
  assign overflow    = overflow_r;
  assign drop_count  = drop_cnt_r;

  // Handshake decode: an entry is freed only when its last beat is taken, and
  // that same cycle makes room for a push arriving on a full buffer.
  always_comb begin
    hs_s          = m_valid_r & bus.m_ready;
    pop_s         = hs_s & m_last_r;
    push_ok_s     = bus.coeff_valid & (~fifo_full_s | pop_s);
    drop_s        = bus.coeff_valid & ~push_ok_s;
    remain_s      = (fifo_level_s > LVL_W'(1)) | push_ok_s;
    beat_inc_s    = beat_r + BEAT_IDX_W'(1);
    first_slice_s = fifo_head_nxt_s[COEFF_W-1 -: BEAT_W];
    next_slice_s  = BEAT_W'(fifo_rd_data_s >> beat_shift(int'(beat_inc_s), BEAT_W));
  end

  // Beat FSM: registered stream outputs, held stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      beat_r    <= {BEAT_IDX_W{1'b0}};
      m_data_r  <= {BEAT_W{1'b0}};
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s || push_ok_s) begin
            state_r   <= ST_STREAM;
            beat_r    <= {BEAT_IDX_W{1'b0}};
            m_data_r  <= first_slice_s;
            m_valid_r <= 1'b1;
            m_last_r  <= (BEATS == 1);
          end else begin
            m_data_r  <= {BEAT_W{1'b0}};
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (hs_s) begin
            if (m_last_r) begin
              beat_r <= {BEAT_IDX_W{1'b0}};
              if (remain_s) begin
                // Next entry follows directly, no bubble.
                m_data_r  <= first_slice_s;
                m_valid_r <= 1'b1;
                m_last_r  <= (BEATS == 1);
              end else begin
                state_r   <= ST_IDLE;
                m_data_r  <= {BEAT_W{1'b0}};
                m_valid_r <= 1'b0;
                m_last_r  <= 1'b0;
              end
            end else begin
              beat_r   <= beat_inc_s;
              m_data_r <= next_slice_s;
              m_last_r <= (beat_inc_s == BEAT_IDX_W'(BEATS-1));
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          beat_r    <= {BEAT_IDX_W{1'b0}};
          m_data_r  <= {BEAT_W{1'b0}};
          m_valid_r <= 1'b0;
          m_last_r  <= 1'b0;
        end
      endcase
    end
  end

  // Drop status: a drop in the same cycle as a clear wins and counts as one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (clr_status) begin
        drop_cnt_r <= CNT_W'(1);
      end else if (drop_cnt_r != {CNT_W{1'b1}}) begin
        drop_cnt_r <= drop_cnt_r + CNT_W'(1);
      end
    end else if (clr_status) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_coeff_stream_packer.sv
// Bench for coeff_stream_packer: directed scenarios followed by random traffic,
// all compared against a queue-based model of the buffered coefficients.
module tb_coeff_stream_packer;

  localparam int DEPTH   = 4;
  localparam int BEAT_W  = 32;
  localparam int CNT_W   = 4;
  localparam int COEFF_W = 128;
  localparam int BEATS   = COEFF_W / BEAT_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        fifo_level;
  logic              overflow;
  logic [CNT_W-1:0]  drop_count;
  logic              clr_status;

  int n_checks = 0;
  int n_errors = 0;

  // Model: entries held (head is being streamed), beat index of head, status.
  logic [COEFF_W-1:0] mq[$];
  int                 mbeat;
  logic               movf;
  int                 mcnt;
  logic [BEAT_W-1:0]  got[$];

  coeff_stream_packer_if #(.COEFF_W(COEFF_W), .BEAT_W(BEAT_W)) bus();

  coeff_stream_packer #(
    .DEPTH  (DEPTH),
    .BEAT_W (BEAT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .clr_status (clr_status)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] exp_beat(input logic [COEFF_W-1:0] w, input int b);
    return BEAT_W'(w >> (BEAT_W * (BEATS - 1 - b)));
  endfunction

  function automatic logic [COEFF_W-1:0] mkw(input int k);
    return {32'(32'hA000_0000 + k), 32'(32'hB000_0000 + k),
            32'(32'hC000_0000 + k), 32'(32'hD000_0000 + k)};
  endfunction

  task automatic model_reset();
    mq.delete();
    mbeat = 0;
    movf  = 1'b0;
    mcnt  = 0;
  endtask

  task automatic model_step(input logic cv, input logic [COEFF_W-1:0] din,
                            input logic rdy, input logic clr);
    bit hs, last, accept;
    hs     = (mq.size() > 0) && rdy;
    last   = hs && (mbeat == BEATS - 1);
    accept = cv && ((mq.size() < DEPTH) || last);
    if (hs) begin
      if (last) begin
        void'(mq.pop_front());
        mbeat = 0;
      end else begin
        mbeat++;
      end
    end
    if (accept) mq.push_back(din);
    if (cv && !accept) begin
      movf = 1'b1;
      if (clr) mcnt = 1;
      else if (mcnt < CNT_MAX) mcnt++;
    end else if (clr) begin
      movf = 1'b0;
      mcnt = 0;
    end
  endtask

  task automatic check_outputs();
    logic [COEFF_W-1:0] h;
    check_val("m_valid", 128'(bus.m_valid), 128'(mq.size() > 0));
    check_val("fifo_level", 128'(fifo_level), 128'(mq.size()));
    check_val("overflow", 128'(overflow), 128'(movf));
    check_val("drop_count", 128'(drop_count), 128'(mcnt));
    if (mq.size() > 0) begin
      h = mq[0];
      check_val("m_data", 128'(bus.m_data), 128'(exp_beat(h, mbeat)));
      check_val("m_last", 128'(bus.m_last), 128'(mbeat == BEATS - 1));
    end
  endtask

  // Called at a negedge: drive, advance model, clock once, check at next negedge.
  task automatic step(input logic cv, input logic [COEFF_W-1:0] din,
                      input logic rdy, input logic clr);
    bus.coeff_valid = cv;
    bus.coeff_in    = din;
    bus.m_ready     = rdy;
    clr_status      = clr;
    if (bus.m_valid && rdy) got.push_back(bus.m_data);
    model_step(cv, din, rdy, clr);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [COEFF_W-1:0] c0;
    c0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    rst             = 1'b1;
    bus.coeff_valid = 1'b0;
    bus.coeff_in    = '0;
    bus.m_ready     = 1'b0;
    clr_status      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("rst_m_valid", 128'(bus.m_valid), 128'(0));
    check_val("rst_m_last", 128'(bus.m_last), 128'(0));
    check_val("rst_m_data", 128'(bus.m_data), 128'(0));
    check_val("rst_level", 128'(fifo_level), 128'(0));
    check_val("rst_overflow", 128'(overflow), 128'(0));
    check_val("rst_drop_count", 128'(drop_count), 128'(0));
    rst = 1'b0;

    // Single coefficient, m_ready held high.
    got.delete();
    step(1'b1, c0, 1'b1, 1'b0);
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);
    check_val("single_nbeats", 128'(got.size()), 128'(4));
    if (got.size() == 4) begin
      check_val("single_b0", 128'(got[0]), 128'(32'h00112233));
      check_val("single_b1", 128'(got[1]), 128'(32'h44556677));
      check_val("single_b2", 128'(got[2]), 128'(32'h8899AABB));
      check_val("single_b3", 128'(got[3]), 128'(32'hCCDDEEFF));
    end

    // Backpressure for five cycles, then release.
    got.delete();
    step(1'b1, c0, 1'b0, 1'b0);
    repeat (5) step(1'b0, '0, 1'b0, 1'b0);
    check_val("bp_hold_data", 128'(bus.m_data), 128'(32'h00112233));
    check_val("bp_hold_valid", 128'(bus.m_valid), 128'(1));
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);
    check_val("bp_nbeats", 128'(got.size()), 128'(4));
    if (got.size() == 4) begin
      check_val("bp_b0", 128'(got[0]), 128'(32'h00112233));
      check_val("bp_b3", 128'(got[3]), 128'(32'hCCDDEEFF));
    end

    // Overflow: six pushes into a stalled buffer.
    got.delete();
    for (int k = 0; k < 6; k++) step(1'b1, mkw(k), 1'b0, 1'b0);
    check_val("ovf_level", 128'(fifo_level), 128'(4));
    check_val("ovf_flag", 128'(overflow), 128'(1));
    check_val("ovf_count", 128'(drop_count), 128'(2));
    repeat (18) step(1'b0, '0, 1'b1, 1'b0);
    check_val("ovf_nbeats", 128'(got.size()), 128'(16));
    if (got.size() == 16) begin
      for (int k = 0; k < 4; k++)
        check_val("ovf_word", 128'(got[4*k]), 128'(32'hA000_0000 + k));
    end
    step(1'b0, '0, 1'b1, 1'b1);
    check_val("clr_flag", 128'(overflow), 128'(0));
    check_val("clr_count", 128'(drop_count), 128'(0));

    // Push on a full buffer together with the last-beat handshake.
    for (int k = 10; k < 14; k++) step(1'b1, mkw(k), 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, mkw(14), 1'b1, 1'b0);
    check_val("fullpop_level", 128'(fifo_level), 128'(4));
    check_val("fullpop_count", 128'(drop_count), 128'(0));
    check_val("fullpop_flag", 128'(overflow), 128'(0));
    repeat (20) step(1'b0, '0, 1'b1, 1'b0);

    // Back-to-back: one push every four cycles, stream must never bubble.
    got.delete();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, mkw(20 + i), 1'b1, 1'b0);
      check_val("b2b_valid", 128'(bus.m_valid), 128'(1));
      for (int j = 0; j < 3; j++) begin
        step(1'b0, '0, 1'b1, 1'b0);
        check_val("b2b_valid", 128'(bus.m_valid), 128'(1));
      end
    end
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    check_val("b2b_nbeats", 128'(got.size()), 128'(24));

    // Reset during beat 2 with three entries queued.
    for (int k = 30; k < 33; k++) step(1'b1, mkw(k), 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);
    check_val("mid_beat2", 128'(bus.m_data), 128'(32'hC000_0000 + 30));
    rst = 1'b1;
    #1;
    check_val("mid_rst_valid", 128'(bus.m_valid), 128'(0));
    check_val("mid_rst_level", 128'(fifo_level), 128'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    repeat (8) step(1'b0, '0, 1'b1, 1'b0);
    check_val("mid_no_beats", 128'(got.size()), 128'(0));

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)),
           {$urandom, $urandom, $urandom, $urandom},
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 31) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/coeff_stream_packer.md
Name: coeff_stream_packer

Overview:
- Sits directly downstream of the fractal encoder kernel. It captures each 128-bit fractal coefficient word on the kernel's single-cycle valid pulse.
- Captured words are buffered in a small FIFO and serialised as 32-bit beats on a valid/ready stream toward the HBM3 write path.
- The producer has no backpressure, so the block absorbs bursts, drops on overflow and reports drops through status outputs.

Parameters:
- DEPTH, 4, number of 128-bit coefficient entries buffered; power of two, at least 2.
- BEAT_W, 32, output beat width; the 128-bit coefficient is split into 128/BEAT_W = 4 beats.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  single clock domain
- rst  in  1  asynchronous, active-high reset
- coeff_in  in  128  coefficient word from the fractal encoder
- coeff_valid  in  1  qualifies coeff_in for one cycle; no ready returned
- m_data  out  32  output beat
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts the beat
- m_last  out  1  high on the final beat (beat 3) of a coefficient
- fifo_level  out  $clog2(DEPTH+1)  number of entries held, including the entry being streamed
- overflow  out  1  sticky; set when a coefficient is dropped
- drop_count  out  CNT_W  saturating count of dropped coefficients
- clr_status  in  1  synchronous clear of overflow and drop_count

Behaviour:
- Reset (async, rst=1): m_valid=0, m_last=0, m_data=0, fifo_level=0, overflow=0, drop_count=0, beat counter=0, FSM=IDLE, FIFO pointers=0. Reset mid-stream discards all entries and any partial beat sequence, with no further output.
- Push: coeff_valid=1 writes coeff_in at the write pointer when fifo_level<DEPTH. It is also written when fifo_level==DEPTH and a m_last handshake (m_valid&m_ready&m_last) occurs in the same cycle.
- Drop: in all other cases a push is dropped. overflow<=1, and drop_count increments, saturating at all ones.
- Simultaneous push and pop: fifo_level is unchanged when a pop and an accepted push coincide.
- Pointer wrap: read and write pointers wrap modulo DEPTH.
- Pop: an entry is freed only on the handshake of its m_last beat.
- FSM IDLE: m_valid=0. If fifo_level>0, or an accepted push occurs this cycle, move to STREAM with beat=0.
- FSM STREAM: m_valid=1 and m_data = entry[127-32*beat -: 32], so beat 0 is bits [127:96], sent MSB-first. m_last=(beat==3).
  - On m_valid&m_ready: beat<=beat+1.
  - On the beat-3 handshake: beat<=0, and the FSM stays in STREAM if another entry remains (back-to-back, no bubble), otherwise goes to IDLE.
- Latency: coeff_valid at cycle N into an empty block gives m_valid=1 with beat 0 at cycle N+1. Sustained throughput is 1 coefficient per 4 cycles when m_ready=1.
- AXI-style stability: while m_valid=1 and m_ready=0, m_data and m_last hold. m_valid does not drop until the handshake.
- Outputs are registered: m_data, m_valid and m_last come from flops; m_data is loaded from the FIFO read port.
- clr_status: clears overflow and drop_count next cycle. If a drop coincides with clr_status, the drop wins: overflow=1, drop_count=1.
- fifo_level reflects the registered occupancy after the current cycle's push/pop.

Decomposition:
- Shared package (fractal_pkg):
  - COEFF_W=128
  - BEAT_W default
  - BEATS_PER_COEFF=4
  - FSM state encoding (IDLE=0, STREAM=1)
- Sub-module coeff_fifo: generic synchronous FIFO (DEPTH x 128) with push/pop/level/full/empty and registered read data.
- The packer wraps coeff_fifo with the beat FSM and status logic.

Test Plan:
- Single coefficient: rst then release; coeff_in=0x00112233_44556677_8899AABB_CCDDEEFF, valid 1 cycle, m_ready=1 -> beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on cycles N+1..N+4; m_last only on the 4th; fifo_level returns to 0.
- Backpressure: same input, m_ready=0 for 5 cycles then 1 -> m_data=0x00112233 and m_valid=1 held throughout; all beats in order, no duplicates or losses.
- Overflow: m_ready=0, 6 pushes of distinct values -> fifo_level=4, overflow=1, drop_count=2. Release m_ready -> exactly the first 4 values streamed; clr_status -> overflow=0, drop_count=0.
- Push on full with pop: fill 4 entries, then assert a push in the same cycle as the m_last handshake -> push accepted, fifo_level stays 4, drop_count=0.
- Back-to-back: push every 4 cycles with m_ready=1 -> continuous m_valid with no bubble between m_last and the next beat 0.
- Reset mid-stream: assert rst during beat 2 with 3 entries queued -> m_valid=0 immediately (async). After release, no beats are emitted and fifo_level=0.
